// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer: PC register driving a combinational imem, 2-entry fetch queue towards decode.
// First word visible 2 cycles after enable; stalls with PC held when the queue is full and decode is not ready.
`timescale 1ns/1ps
module imem_fetch_sequencer #(
  parameter int                ADDR_W   = 7,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic [DATA_W-1:0]   e0_dat_q, e0_dat_d, e1_dat_q, e1_dat_d;
  logic                deq;
  logic                push;

  assign deq = (cnt_q != 2'd0) && inst_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    e0_pc_d  = e0_pc_q;
    e0_dat_d = e0_dat_q;
    e1_pc_d  = e1_pc_q;
    e1_dat_d = e1_dat_q;
    push     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!redirect_valid && enable) state_d = RUN;
      end
      RUN: begin
        // Fetch only while staying in RUN so dropping enable never queues a fresh word.
        if (!redirect_valid && !enable) state_d = DRAIN;
        push = !redirect_valid && enable && ((cnt_q != 2'd2) || deq);
      end
      DRAIN: begin
        if (redirect_valid)                         state_d = enable ? RUN : IDLE;
        else if (enable)                            state_d = RUN;
        else if ((cnt_q - 2'(deq)) == 2'd0)         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      cnt_d = 2'd0;
      pc_d  = redirect_pc;
    end else begin
      if (push) pc_d = pc_q + ADDR_W'(1);
      case ({push, deq})
        2'b10: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) begin
            e0_pc_d  = pc_q;
            e0_dat_d = imem_data;
          end else begin
            e1_pc_d  = pc_q;
            e1_dat_d = imem_data;
          end
        end
        2'b01: begin
          cnt_d = cnt_q - 2'd1;
          // Shift only when a second entry exists, so the last head stays visible.
          if (cnt_q == 2'd2) begin
            e0_pc_d  = e1_pc_q;
            e0_dat_d = e1_dat_q;
          end
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            e0_pc_d  = pc_q;
            e0_dat_d = imem_data;
          end else begin
            e0_pc_d  = e1_pc_q;
            e0_dat_d = e1_dat_q;
            e1_pc_d  = pc_q;
            e1_dat_d = imem_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= 2'd0;
      e0_pc_q  <= '0;
      e0_dat_q <= '0;
      e1_pc_q  <= '0;
      e1_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      e0_pc_q  <= e0_pc_d;
      e0_dat_q <= e0_dat_d;
      e1_pc_q  <= e1_pc_d;
      e1_dat_q <= e1_dat_d;
    end
  end

  assign imem_addr  = pc_q;
  assign inst_valid = (cnt_q != 2'd0);
  assign inst       = e0_dat_q;
  assign inst_pc    = e0_pc_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer: start-up, backpressure, redirect, wrap, drain and async reset.
`timescale 1ns/1ps
module tb_imem_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [6:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [6:0]  redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [6:0]  inst_pc;
  logic        inst_ready;
  logic        busy;

  logic [31:0] mem [128];
  int          n_cmp;
  int          n_err;

  imem_fetch_sequencer #(.ADDR_W(7), .DATA_W(32), .RESET_PC(7'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .busy           (busy)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [6:0] pc, input logic [31:0] word);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, "_pc"},    {25'd0, inst_pc},    {25'd0, pc});
    chk({tag, "_inst"},  inst,                word);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h8D40_0000;
    mem[1] = 32'h8D41_0001;
    mem[2] = 32'h0001_1020;

    rst_n = 1'b0; enable = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 7'd0;
    #3;
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst",  inst, 32'd0);
    chk("rst_pc",    {25'd0, inst_pc}, 32'd0);
    chk("rst_addr",  {25'd0, imem_addr}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Start-up and streaming
    enable = 1'b1; inst_ready = 1'b1;
    step();
    chk("start_valid", {31'd0, inst_valid}, 32'd0);
    chk("start_busy",  {31'd0, busy}, 32'd1);
    chk("start_addr",  {25'd0, imem_addr}, 32'd0);
    step();
    chk_head("first", 7'd0, 32'h8D40_0000);
    chk("first_addr", {25'd0, imem_addr}, 32'd1);
    step();
    chk_head("second", 7'd1, 32'h8D41_0001);
    step();
    chk_head("third", 7'd2, 32'h0001_1020);
    chk("third_addr", {25'd0, imem_addr}, 32'd3);

    // Backpressure: restart at 0 with decode stalled
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 7'd0;
    step();
    redirect_valid = 1'b0;
    chk("bp_redir_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk_head("bp_first", 7'd0, 32'h8D40_0000);
    step(); step(); step(); step();
    chk_head("bp_hold", 7'd0, 32'h8D40_0000);
    chk("bp_addr", {25'd0, imem_addr}, 32'd2);
    inst_ready = 1'b1;
    step();
    chk_head("bp_rel1", 7'd1, 32'h8D41_0001);
    step();
    chk_head("bp_rel2", 7'd2, 32'h0001_1020);
    chk("bp_rel_addr", {25'd0, imem_addr}, 32'd4);

    // Redirect with two entries queued and a head handshake in flight
    redirect_valid = 1'b1; redirect_pc = 7'h40;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", {31'd0, inst_valid}, 32'd0);
    chk("rd_addr",  {25'd0, imem_addr}, 32'h40);
    step();
    chk_head("rd_40", 7'h40, 32'hA000_0040);
    step();
    chk_head("rd_41", 7'h41, 32'hA000_0041);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 7'd126;
    step();
    redirect_valid = 1'b0;
    chk("wr_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk_head("wr_126", 7'd126, 32'hA000_007E);
    step();
    chk_head("wr_127", 7'd127, 32'hA000_007F);
    step();
    chk_head("wr_0", 7'd0, 32'h8D40_0000);
    step();
    chk_head("wr_1", 7'd1, 32'h8D41_0001);

    // Fill to two entries, then drop enable
    inst_ready = 1'b0;
    step();
    chk_head("fill", 7'd1, 32'h8D41_0001);
    chk("fill_addr", {25'd0, imem_addr}, 32'd3);
    enable = 1'b0; inst_ready = 1'b1;
    step();
    chk_head("drain1", 7'd2, 32'h0001_1020);
    chk("drain1_busy", {31'd0, busy}, 32'd1);
    chk("drain1_addr", {25'd0, imem_addr}, 32'd3);
    step();
    chk("drain2_valid", {31'd0, inst_valid}, 32'd0);
    chk("drain2_busy",  {31'd0, busy}, 32'd0);
    chk("drain2_addr",  {25'd0, imem_addr}, 32'd3);
    step();
    chk("idle_valid", {31'd0, inst_valid}, 32'd0);
    chk("idle_addr",  {25'd0, imem_addr}, 32'd3);

    // Async reset with a full queue
    enable = 1'b1; inst_ready = 1'b0;
    step(); step(); step();
    chk_head("full", 7'd3, 32'hA000_0003);
    chk("full_addr", {25'd0, imem_addr}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_addr",  {25'd0, imem_addr}, 32'd0);
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    chk("arst_pc",    {25'd0, inst_pc}, 32'd0);
    step();
    rst_n = 1'b1; inst_ready = 1'b1;
    step();
    chk("re_start_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk_head("re_first", 7'd0, 32'h8D40_0000);
    step();
    chk_head("re_second", 7'd1, 32'h8D41_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
# imem_fetch_sequencer

Instruction fetch sequencer sitting between the 128-word instruction memory and the decode stage. Holds the program counter, drives the instruction-memory address, and captures each returned word with its PC into a 2-entry fetch queue. The queue is presented to decode through a valid/ready handshake. Decode or branch logic redirects fetch with a single-cycle redirect strobe that flushes the queue.

## Interface
- ADDR_W, 7, instruction-memory word-address width; PC wraps modulo 2^ADDR_W
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; level-sensitive
- imem_addr  out  ADDR_W  word address to instruction memory; equals the PC register
- imem_data  in  DATA_W  instruction word, combinationally valid for imem_addr in the same cycle
- redirect_valid  in  1  one-cycle strobe: flush queue and load redirect_pc
- redirect_pc  in  ADDR_W  new PC
- inst_valid  out  1  queue head valid
- inst  out  DATA_W  queue-head instruction
- inst_pc  out  ADDR_W  queue-head PC
- inst_ready  in  1  decode accepts the head when inst_valid is also 1
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: no fetch; queue empty.
  - RUN: fetch when there is space.
  - DRAIN: no fetch; the queue is emptied by decode.
- State transitions:
  - IDLE→RUN when enable=1.
  - RUN→DRAIN when enable=0.
  - DRAIN→RUN when enable=1.
  - DRAIN→IDLE when the queue is empty after this cycle's dequeue and enable=0.
- Dequeue: fires when inst_valid && inst_ready. The head advances to the second entry if present.
- Push: allowed only in RUN. Condition is count<2, or count==2 with a dequeue in the same cycle.
  - On push, {pc, imem_data} goes to the queue tail and pc←pc+1 mod 2^ADDR_W. 127 wraps to 0 with no error.
- No push occurs in the cycle a state transition out of IDLE is taken. The transition cycle only changes state.
- Simultaneous push and dequeue with count==1 or count==2: count is unchanged and order is preserved.
- Redirect has priority over push and dequeue:
  - Queue count←0 and pc←redirect_pc; no push that cycle.
  - A head handshake in the same cycle is counted as consumed; no data is retained.
  - State after redirect:
    - From RUN: stays RUN.
    - From DRAIN: IDLE if enable=0, else RUN.
    - From IDLE: stays IDLE with the new pc.
- inst and inst_pc are registered queue-head contents. Their value is don't-care-stable (last head) when inst_valid=0.
- Reset, asynchronous at any time including mid-fetch:
  - state=IDLE, pc=RESET_PC, count=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - imem_addr=RESET_PC, busy=0.

## Timing
- imem_addr changes only after a clock edge and is stable for the full cycle.
- Memory read is combinational and is consumed at the next edge.
- Start-up:
  - Edge N samples enable=1 in IDLE and moves to RUN.
  - Edge N+1 pushes PC RESET_PC.
  - inst_valid is high after edge N+1, so the first instruction appears 2 cycles after enable is sampled.
- Throughput: 1 instruction/cycle while inst_ready=1.
- With inst_ready=0, the queue fills in 2 cycles and fetch stalls with pc held. imem_addr stays at the next unfetched PC.
- Redirect latency:
  - Strobe sampled at edge R; inst_valid=0 after R.
  - The word at redirect_pc is pushed at R+1 if the block is in RUN, and is visible after R+1.
- busy rises after the IDLE→RUN edge and falls after the DRAIN→IDLE edge.

## Test plan
- Memory loaded with word0=0x8D400000, word1=0x8D410001, word2=0x00011020. Reset, then enable=1 with inst_ready=1:
  - Two cycles after enable is sampled, inst=0x8D400000 with inst_pc=0.
  - Then 0x8D410001 with pc 1, then 0x00011020 with pc 2, on consecutive cycles.
- Backpressure: inst_ready=0 for 5 cycles after the first valid.
  - Queue holds pcs 0 and 1; imem_addr stays 2.
  - On release, pcs 0, 1, 2 are delivered in order with none lost or duplicated.
- Redirect to 0x40 while the queue holds two entries:
  - inst_valid=0 for one cycle, then inst_pc=0x40 and 0x41.
  - Old entries are never presented.
- Wrap: redirect to 126, run freely.
  - Delivered PC sequence is 126, 127, 0, 1.
- enable dropped with 2 entries queued and inst_ready=1:
  - Both entries are delivered, no new push occurs, busy falls, and imem_addr holds.
- Assert rst_n=0 mid-stream with the queue full:
  - inst_valid=0, imem_addr=0 and busy=0 take effect immediately, without waiting for a clock edge.
  - Release, then enable: delivery restarts at pc 0.
